rf_write_arbiter: RTL and testbench

- Shares the register file's single write port (wr_enable/RD/WD) between three writeback sources: ALU, LOAD (memory return) and HOST (debug/loader).
- Each source gets a small FIFO with a valid/ready handshake. Fixed priority applies, with an aging override so no source starves.
- Writes to hardware-owned registers (R13 flag, R15 zero) are dropped.
- Exports a per-register pending-write mask that the decode stage uses for hazard stalls.

---
 rtl/rf_arb_pkg.sv | 32 +++
 rtl/rf_write_arbiter_fifo.sv | 69 ++++++
 rtl/rf_write_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Entries carry {rd, wd}; the rd field always sits in the top RD_W bits.
package rf_arb_pkg;

  localparam int RF_DW = 32;
  localparam int RD_W  = 4;
  localparam int NREG  = 16;
  localparam int NSRC  = 3;

  localparam logic [NREG-1:0] PROT_MASK_DEFAULT = 16'hA000;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_LD   = 2'd1,
    SRC_HOST = 2'd2
  } src_e;

  typedef enum logic {
    OUT_IDLE  = 1'b0,
    OUT_WRITE = 1'b1
  } out_state_e;

  typedef struct packed {
    logic [RD_W-1:0]  rd;
    logic [RF_DW-1:0] wd;
  } wb_req_t;

  function automatic logic [NREG-1:0] rd_onehot(input logic [RD_W-1:0] rd);
    return 16'(1) << rd;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_fifo.sv
// Small in-order writeback FIFO; also exposes every slot's valid bit and rd
// field so the parent can build the pending-write mask.
module wb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = RD_W + RF_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      ent_valid,
  output logic [DEPTH*RD_W-1:0] ent_rd
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: slot validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [AW-1:0] offset;
    assign offset                  = AW'(gi) - rd_ptr_q;
    assign ent_valid[gi]           = ({1'b0, offset} < count_q);
    assign ent_rd[gi*RD_W +: RD_W] = mem[gi][WIDTH-1 -: RD_W];
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU, LOAD and HOST writeback
// queues with fixed priority plus aging; drops writes to hardware-owned regs.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int              DW        = 32,
  parameter int              DEPTH     = 2,
  parameter int              MAX_WAIT  = 4,
  parameter logic [NREG-1:0] PROT_MASK = PROT_MASK_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [3:0]      alu_rd,
  input  logic [DW-1:0]   alu_wd,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [3:0]      ld_rd,
  input  logic [DW-1:0]   ld_wd,
  input  logic            host_valid,
  output logic            host_ready,
  input  logic [3:0]      host_rd,
  input  logic [DW-1:0]   host_wd,
  input  logic            hold,
  output logic            rf_we,
  output logic [3:0]      rf_rd,
  output logic [DW-1:0]   rf_wd,
  output logic            drop,
  output logic [NREG-1:0] pending
);

  localparam int WIDTH = RD_W + DW;
  localparam int WW    = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [NSRC-1:0]      src_valid, src_ready, src_push, src_pop;
  logic [NSRC-1:0]      src_full, src_empty;
  logic [WIDTH-1:0]     src_din  [NSRC];
  logic [WIDTH-1:0]     src_dout [NSRC];
  logic [DEPTH-1:0]     src_ent_valid [NSRC];
  logic [DEPTH*RD_W-1:0] src_ent_rd   [NSRC];

  assign src_valid          = {host_valid, ld_valid, alu_valid};
  assign src_din[SRC_ALU]   = {alu_rd, alu_wd};
  assign src_din[SRC_LD]    = {ld_rd, ld_wd};
  assign src_din[SRC_HOST]  = {host_rd, host_wd};

  assign alu_ready  = src_ready[SRC_ALU];
  assign ld_ready   = src_ready[SRC_LD];
  assign host_ready = src_ready[SRC_HOST];

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    // Ready is a pure function of fullness so it never combinationally
    // depends on this cycle's arbitration.
    assign src_ready[gi] = !src_full[gi] && !rst;
    assign src_push[gi]  = src_valid[gi] && src_ready[gi];

    wb_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(WIDTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (src_push[gi]),
      .pop       (src_pop[gi]),
      .din       (src_din[gi]),
      .dout      (src_dout[gi]),
      .full      (src_full[gi]),
      .empty     (src_empty[gi]),
      .ent_valid (src_ent_valid[gi]),
      .ent_rd    (src_ent_rd[gi])
    );
  end

  // ---------------- arbitration ----------------
  logic [WW-1:0]    wait_ld_q, wait_ld_d;
  logic [WW-1:0]    wait_host_q, wait_host_d;
  logic             grant_valid;
  src_e             grant_src;
  logic [WIDTH-1:0] grant_req;
  logic [RD_W-1:0]  grant_rd;
  logic [DW-1:0]    grant_wd;
  logic             grant_prot;

  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_ALU;
    if (!hold) begin
      if (!src_empty[SRC_LD] && wait_ld_q >= WAIT_MAX) begin
        grant_valid = 1'b1;
        grant_src   = SRC_LD;
      end else if (!src_empty[SRC_HOST] && wait_host_q >= WAIT_MAX) begin
        grant_valid = 1'b1;
        grant_src   = SRC_HOST;
      end else if (!src_empty[SRC_ALU]) begin
        grant_valid = 1'b1;
        grant_src   = SRC_ALU;
      end else if (!src_empty[SRC_LD]) begin
        grant_valid = 1'b1;
        grant_src   = SRC_LD;
      end else if (!src_empty[SRC_HOST]) begin
        grant_valid = 1'b1;
        grant_src   = SRC_HOST;
      end
    end
  end

  always_comb begin
    src_pop = '0;
    if (grant_valid) src_pop[grant_src] = 1'b1;
  end

  assign grant_req  = src_dout[grant_src];
  assign grant_rd   = grant_req[WIDTH-1 -: RD_W];
  assign grant_wd   = grant_req[DW-1:0];
  assign grant_prot = PROT_MASK[grant_rd];

  // Aging: a head that keeps losing saturates at MAX_WAIT and then outranks ALU.
  always_comb begin
    wait_ld_d   = wait_ld_q;
    wait_host_d = wait_host_q;
    if (!hold) begin
      if (src_empty[SRC_LD] || (grant_valid && grant_src == SRC_LD))
        wait_ld_d = '0;
      else if (wait_ld_q < WAIT_MAX)
        wait_ld_d = wait_ld_q + 1'b1;

      if (src_empty[SRC_HOST] || (grant_valid && grant_src == SRC_HOST))
        wait_host_d = '0;
      else if (wait_host_q < WAIT_MAX)
        wait_host_d = wait_host_q + 1'b1;
    end
  end

  // ---------------- output stage ----------------
  out_state_e      out_state_q, out_state_d;
  logic [RD_W-1:0] out_rd_q, out_rd_d;
  logic [DW-1:0]   out_wd_q, out_wd_d;
  logic            drop_q, drop_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state_q <= OUT_IDLE;
      out_rd_q    <= '0;
      out_wd_q    <= '0;
      drop_q      <= 1'b0;
      wait_ld_q   <= '0;
      wait_host_q <= '0;
    end else begin
      out_state_q <= out_state_d;
      out_rd_q    <= out_rd_d;
      out_wd_q    <= out_wd_d;
      drop_q      <= drop_d;
      wait_ld_q   <= wait_ld_d;
      wait_host_q <= wait_host_d;
    end
  end

  // Protected heads are still popped; they only turn into a drop pulse.
  always_comb begin
    out_state_d = OUT_IDLE;
    out_rd_d    = out_rd_q;
    out_wd_d    = out_wd_q;
    drop_d      = grant_valid && grant_prot;
    if (grant_valid && !grant_prot) begin
      out_state_d = OUT_WRITE;
      out_rd_d    = grant_rd;
      out_wd_d    = grant_wd;
    end
  end

  always_comb begin
    rf_we = (out_state_q == OUT_WRITE);
    rf_rd = out_rd_q;
    rf_wd = out_wd_q;
    drop  = drop_q;
  end

  // ---------------- pending-write mask ----------------
  logic [NREG-1:0] pending_raw;

  always_comb begin
    pending_raw = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (src_ent_valid[s][e])
          pending_raw = pending_raw | rd_onehot(src_ent_rd[s][e*RD_W +: RD_W]);
      end
    end
    if (out_state_q == OUT_WRITE)
      pending_raw = pending_raw | rd_onehot(out_rd_q);
  end

  assign pending = pending_raw & ~PROT_MASK;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected writes are queued as
// stimulus is driven and checked in order whenever rf_we fires.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, host_valid;
  logic        alu_ready, ld_ready, host_ready;
  logic [3:0]  alu_rd, ld_rd, host_rd;
  logic [31:0] alu_wd, ld_wd, host_wd;
  logic        hold;
  logic        rf_we;
  logic [3:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        drop;
  logic [15:0] pending;

  int n_checks = 0;
  int n_errors = 0;
  int drop_cnt = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_wd     (alu_wd),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_wd      (ld_wd),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_rd    (host_rd),
    .host_wd    (host_wd),
    .hold       (hold),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wd      (rf_wd),
    .drop       (drop),
    .pending    (pending)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end else begin
      $display("ok   %s: %0h at %0t", tag, act, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (exp_q.size() == 0) begin
        chk("spurious_we", 64'(rf_we), 64'd0);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        chk("wb_rd", 64'(rf_rd), 64'(e[35:32]));
        chk("wb_wd", 64'(rf_wd), 64'(e[31:0]));
      end
    end
    if (!rst && drop) drop_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy;
    int   acc;
    int   cycles;

    rst = 1'b1;
    hold = 1'b0;
    alu_valid = 1'b0; ld_valid = 1'b0; host_valid = 1'b0;
    alu_rd = '0; ld_rd = '0; host_rd = '0;
    alu_wd = '0; ld_wd = '0; host_wd = '0;

    // ---- reset state ----
    step(); step();
    chk("rst_rf_we", 64'(rf_we), 0);
    chk("rst_rf_rd", 64'(rf_rd), 0);
    chk("rst_rf_wd", 64'(rf_wd), 0);
    chk("rst_drop", 64'(drop), 0);
    chk("rst_pending", 64'(pending), 0);
    chk("rst_ready", 64'({alu_ready, ld_ready, host_ready}), 0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 64'({alu_ready, ld_ready, host_ready}), 64'h7);

    // ---- single ALU write, latency and pending window ----
    alu_valid = 1'b1; alu_rd = 4'd3; alu_wd = 32'h1234;
    exp_q.push_back({4'd3, 32'h1234});
    step();
    alu_valid = 1'b0;
    chk("t1_pend_n1", 64'(pending[3]), 1);
    chk("t1_we_n1", 64'(rf_we), 0);
    step();
    chk("t1_we_n2", 64'(rf_we), 1);
    chk("t1_rd_n2", 64'(rf_rd), 3);
    chk("t1_wd_n2", 64'(rf_wd), 64'h1234);
    chk("t1_pend_n2", 64'(pending[3]), 1);
    step();
    chk("t1_pend_n3", 64'(pending[3]), 0);
    chk("t1_we_n3", 64'(rf_we), 0);
    step();

    // ---- three sources in the same cycle: ALU, LOAD, HOST order ----
    alu_valid = 1'b1; alu_rd = 4'd1; alu_wd = 32'h11;
    ld_valid = 1'b1;  ld_rd = 4'd2;  ld_wd = 32'h22;
    host_valid = 1'b1; host_rd = 4'd4; host_wd = 32'h44;
    exp_q.push_back({4'd1, 32'h11});
    exp_q.push_back({4'd2, 32'h22});
    exp_q.push_back({4'd4, 32'h44});
    step();
    alu_valid = 1'b0; ld_valid = 1'b0; host_valid = 1'b0;
    chk("t2_pending", 64'(pending), 64'h0016);
    step();
    chk("t2_rd_a", 64'(rf_rd), 1);
    step();
    chk("t2_rd_b", 64'(rf_rd), 2);
    step();
    chk("t2_rd_c", 64'(rf_rd), 4);
    chk("t2_we_c", 64'(rf_we), 1);
    step();
    chk("t2_we_idle", 64'(rf_we), 0);
    step();

    // ---- aging: LOAD waits behind a stream of ALU writes ----
    for (int i = 0; i < 4; i++) exp_q.push_back({4'd5, 32'h500 + 32'(i)});
    exp_q.push_back({4'd6, 32'h600});
    for (int i = 4; i < 8; i++) exp_q.push_back({4'd5, 32'h500 + 32'(i)});
    ld_valid = 1'b1; ld_rd = 4'd6; ld_wd = 32'h600;
    acc = 0;
    cycles = 0;
    while (acc < 8 && cycles < 40) begin
      alu_valid = 1'b1; alu_rd = 4'd5; alu_wd = 32'h500 + 32'(acc);
      rdy = alu_ready;
      step();
      if (cycles == 0) ld_valid = 1'b0;
      if (rdy) acc++;
      cycles++;
      if (cycles == 5) chk("t3_alu_before_age", 64'(rf_wd), 64'h503);
      if (cycles == 6) chk("t3_ld_aged_grant", 64'(rf_rd), 6);
      if (cycles == 7) chk("t3_alu_resumes", 64'(rf_rd), 5);
    end
    alu_valid = 1'b0;
    chk("t3_alu_accepts", 64'(acc), 8);
    repeat (4) step();

    // ---- protected registers are dropped ----
    host_valid = 1'b1; host_rd = 4'd13; host_wd = 32'hdead;
    step();
    host_rd = 4'd15; host_wd = 32'hbeef;
    chk("t4_pend_prot_n1", 64'({pending[15], pending[13]}), 0);
    chk("t4_drop_n1", 64'(drop), 0);
    step();
    host_valid = 1'b0;
    chk("t4_drop_n2", 64'(drop), 1);
    chk("t4_pend_prot_n2", 64'({pending[15], pending[13]}), 0);
    step();
    chk("t4_drop_n3", 64'(drop), 1);
    chk("t4_we_n3", 64'(rf_we), 0);
    step();
    chk("t4_drop_n4", 64'(drop), 0);
    step();

    // ---- hold: fill LOAD queue, then release ----
    hold = 1'b1;
    ld_valid = 1'b1; ld_rd = 4'd7; ld_wd = 32'h700;
    exp_q.push_back({4'd7, 32'h700});
    step();
    ld_rd = 4'd8; ld_wd = 32'h800;
    exp_q.push_back({4'd8, 32'h800});
    step();
    chk("t5_ready_full", 64'(ld_ready), 0);
    chk("t5_pending", 64'(pending), 64'h0180);
    ld_rd = 4'd9; ld_wd = 32'h900;
    exp_q.push_back({4'd9, 32'h900});
    step();
    chk("t5_ready_hold", 64'(ld_ready), 0);
    chk("t5_we_hold", 64'(rf_we), 0);
    hold = 1'b0;
    step();
    chk("t5_ready_after_pop", 64'(ld_ready), 1);
    chk("t5_first_write", 64'(rf_rd), 7);
    step();
    ld_valid = 1'b0;
    chk("t5_second_write", 64'(rf_rd), 8);
    step();
    chk("t5_third_write", 64'(rf_rd), 9);
    repeat (2) step();

    // ---- reset with entries queued ----
    hold = 1'b1;
    alu_valid = 1'b1; alu_rd = 4'd10; alu_wd = 32'ha00;
    ld_valid = 1'b1;  ld_rd = 4'd11;  ld_wd = 32'hb00;
    step();
    alu_valid = 1'b0; ld_valid = 1'b0;
    chk("t6_pending_queued", 64'(pending), 64'h0c00);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", 64'({alu_ready, ld_ready, host_ready}), 0);
    chk("t6_rst_pending", 64'(pending), 0);
    chk("t6_rst_we", 64'(rf_we), 0);
    step(); step();
    rst = 1'b0;
    hold = 1'b0;
    step();
    chk("t6_ready_back", 64'(alu_ready), 1);
    chk("t6_pending_clear", 64'(pending), 0);
    repeat (5) step();

    // ---- final bookkeeping ----
    chk("exp_drained", 64'(exp_q.size()), 0);
    chk("drop_count", 64'(drop_cnt), 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
